// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl
// Host-side debug controller between the UART pair and the core. It decodes
// command bytes, owns the core's stall input (run / halt / single-step) and
// reads back register-file, data-memory, PC and cycle-counter state as
// 4-byte big-endian responses.
//
// Ports:
//   clk             sole clock, rising edge
//   rst             asynchronous active-low reset
//   i_rx_valid      one-cycle pulse: i_rx_data holds a received byte
//   i_rx_data       received byte
//   o_tx_valid      response byte presented (held until i_tx_ready)
//   o_tx_data       response byte
//   i_tx_ready      transmitter accepts the byte this cycle
//   o_stall         1 = pipeline frozen
//   o_running       free-run mode active
//   o_dbg_reg_addr  register-file debug read address
//   i_dbg_reg_data  register data, valid one cycle after the address
//   o_dbg_mem_addr  data-memory debug word address
//   i_dbg_mem_data  memory data, valid one cycle after the address
//   i_dbg_pc        current PC (combinational)
module pipeline_debug_ctrl #(
  parameter int unsigned MEM_ADDR_W = 10,
  parameter logic [7:0]  ACK_BYTE   = 8'hAC,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_tx_valid,
  output logic [7:0]            o_tx_data,
  input  logic                  i_tx_ready,
  output logic                  o_stall,
  output logic                  o_running,
  output logic [4:0]            o_dbg_reg_addr,
  input  logic [31:0]           i_dbg_reg_data,
  output logic [MEM_ADDR_W-1:0] o_dbg_mem_addr,
  input  logic [31:0]           i_dbg_mem_data,
  input  logic [31:0]           i_dbg_pc
);

  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_HALT  = 8'h02;
  localparam logic [7:0] OP_STEP  = 8'h03;
  localparam logic [7:0] OP_RDREG = 8'h04;
  localparam logic [7:0] OP_RDMEM = 8'h05;
  localparam logic [7:0] OP_RDPC  = 8'h06;
  localparam logic [7:0] OP_RDCYC = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARG1    = 3'd1,
    ST_ARG2    = 3'd2,
    ST_STEP    = 3'd3,
    ST_WAIT_RD = 3'd4,
    ST_LOAD    = 3'd5,
    ST_SEND    = 3'd6,
    ST_SEND1   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC  = 2'd2,
    SRC_CYC = 2'd3
  } src_t;

  state_t                state_r, state_nxt_s;
  src_t                  src_r, src_nxt_s;
  logic                  running_r, running_nxt_s;
  logic                  stall_r, stall_nxt_s;
  logic [7:0]            arg_hi_r, arg_hi_nxt_s;
  logic [4:0]            reg_addr_r, reg_addr_nxt_s;
  logic [MEM_ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [23:0]           shift_r, shift_nxt_s;
  logic [1:0]            byte_cnt_r, byte_cnt_nxt_s;
  logic                  tx_valid_r, tx_valid_nxt_s;
  logic [7:0]            tx_data_r, tx_data_nxt_s;
  logic [31:0]           cyc_r;
  logic [31:0]           load_word_s;

  // Select the 32-bit word captured in LOAD
  always_comb begin
    load_word_s = 32'h0000_0000;
    case (src_r)
      SRC_REG: load_word_s = i_dbg_reg_data;
      SRC_MEM: load_word_s = i_dbg_mem_data;
      SRC_PC:  load_word_s = i_dbg_pc;
      SRC_CYC: load_word_s = cyc_r;
      default: load_word_s = 32'h0000_0000;
    endcase
  end

  // Command decode, next state and next values of all registered outputs
  always_comb begin
    state_nxt_s    = state_r;
    src_nxt_s      = src_r;
    running_nxt_s  = running_r;
    arg_hi_nxt_s   = arg_hi_r;
    reg_addr_nxt_s = reg_addr_r;
    mem_addr_nxt_s = mem_addr_r;
    shift_nxt_s    = shift_r;
    byte_cnt_nxt_s = byte_cnt_r;
    tx_valid_nxt_s = tx_valid_r;
    tx_data_nxt_s  = tx_data_r;

    case (state_r)
      ST_IDLE: begin
        if (i_rx_valid) begin
          // While free-running only RUN/HALT are honoured; all else is refused
          // without consuming argument bytes.
          if (running_r && (i_rx_data != OP_RUN) && (i_rx_data != OP_HALT)) begin
            tx_valid_nxt_s = 1'b1;
            tx_data_nxt_s  = ERR_BYTE;
            state_nxt_s    = ST_SEND1;
          end else begin
            case (i_rx_data)
              OP_RUN: begin
                running_nxt_s  = 1'b1;
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = ACK_BYTE;
                state_nxt_s    = ST_SEND1;
              end
              OP_HALT: begin
                running_nxt_s  = 1'b0;
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = ACK_BYTE;
                state_nxt_s    = ST_SEND1;
              end
              OP_STEP:  state_nxt_s = ST_STEP;
              OP_RDREG: begin
                src_nxt_s   = SRC_REG;
                state_nxt_s = ST_ARG1;
              end
              OP_RDMEM: begin
                src_nxt_s   = SRC_MEM;
                state_nxt_s = ST_ARG1;
              end
              OP_RDPC: begin
                src_nxt_s   = SRC_PC;
                state_nxt_s = ST_LOAD;
              end
              OP_RDCYC: begin
                src_nxt_s   = SRC_CYC;
                state_nxt_s = ST_LOAD;
              end
              default: begin
                tx_valid_nxt_s = 1'b1;
                tx_data_nxt_s  = ERR_BYTE;
                state_nxt_s    = ST_SEND1;
              end
            endcase
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARG1: begin
        if (i_rx_valid) begin
          if (src_r == SRC_REG) begin
            reg_addr_nxt_s = i_rx_data[4:0];
            state_nxt_s    = ST_WAIT_RD;
          end else begin
            arg_hi_nxt_s = i_rx_data;
            state_nxt_s  = ST_ARG2;
          end
        end else begin
          state_nxt_s = ST_ARG1;
        end
      end
      ST_ARG2: begin
        if (i_rx_valid) begin
          mem_addr_nxt_s = MEM_ADDR_W'({arg_hi_r, i_rx_data});
          state_nxt_s    = ST_WAIT_RD;
        end else begin
          state_nxt_s = ST_ARG2;
        end
      end
      ST_STEP: begin
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = ACK_BYTE;
        state_nxt_s    = ST_SEND1;
      end
      ST_WAIT_RD: state_nxt_s = ST_LOAD;
      ST_LOAD: begin
        // First (most significant) byte goes straight to the output register.
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = load_word_s[31:24];
        shift_nxt_s    = load_word_s[23:0];
        byte_cnt_nxt_s = 2'd0;
        state_nxt_s    = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          if (byte_cnt_r == 2'd3) begin
            tx_valid_nxt_s = 1'b0;
            state_nxt_s    = ST_IDLE;
          end else begin
            tx_data_nxt_s  = shift_r[23:16];
            shift_nxt_s    = {shift_r[15:0], 8'h00};
            byte_cnt_nxt_s = byte_cnt_r + 2'd1;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_SEND1: begin
        if (i_tx_ready) begin
          tx_valid_nxt_s = 1'b0;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND1;
        end
      end
      default: begin
        tx_valid_nxt_s = 1'b0;
        state_nxt_s    = ST_IDLE;
      end
    endcase

    // Stall is registered from next values so it tracks ~(running | step).
    stall_nxt_s = ~(running_nxt_s | (state_nxt_s == ST_STEP));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_r      <= SRC_REG;
      running_r  <= 1'b0;
      stall_r    <= 1'b1;
      arg_hi_r   <= 8'h00;
      reg_addr_r <= 5'd0;
      mem_addr_r <= '0;
      shift_r    <= 24'h00_0000;
      byte_cnt_r <= 2'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      src_r      <= src_nxt_s;
      running_r  <= running_nxt_s;
      stall_r    <= stall_nxt_s;
      arg_hi_r   <= arg_hi_nxt_s;
      reg_addr_r <= reg_addr_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      shift_r    <= shift_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
    end
  end

  // Free-running cycle counter: counts every released cycle, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_r <= 32'h0000_0000;
    end else if (!stall_r) begin
      cyc_r <= cyc_r + 32'd1;
    end else begin
      cyc_r <= cyc_r;
    end
  end

  assign o_tx_valid     = tx_valid_r;
  assign o_tx_data      = tx_data_r;
  assign o_stall        = stall_r;
  assign o_running      = running_r;
  assign o_dbg_reg_addr = reg_addr_r;
  assign o_dbg_mem_addr = mem_addr_r;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Scoreboard bench for pipeline_debug_ctrl: commands push their expected
// response bytes into a queue, and an independent monitor pops and compares
// every byte the DUT transfers. Expected values come from a command-level
// model (running flag, released-cycle count, register/memory arrays).
module tb_pipeline_debug_ctrl;
  localparam int         MW  = 10;
  localparam logic [7:0] ACK = 8'hAC;
  localparam logic [7:0] ERR = 8'hEE;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rx_valid;
  logic [7:0]    i_rx_data;
  logic          o_tx_valid;
  logic [7:0]    o_tx_data;
  logic          i_tx_ready;
  logic          o_stall;
  logic          o_running;
  logic [4:0]    o_dbg_reg_addr;
  logic [31:0]   i_dbg_reg_data;
  logic [MW-1:0] o_dbg_mem_addr;
  logic [31:0]   i_dbg_mem_data;
  logic [31:0]   i_dbg_pc;

  pipeline_debug_ctrl #(.MEM_ADDR_W(MW)) dut (
    .clk(clk), .rst(rst),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_stall(o_stall), .o_running(o_running),
    .o_dbg_reg_addr(o_dbg_reg_addr), .i_dbg_reg_data(i_dbg_reg_data),
    .o_dbg_mem_addr(o_dbg_mem_addr), .i_dbg_mem_data(i_dbg_mem_data),
    .i_dbg_pc(i_dbg_pc)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          tb_cyc = 0;
  int          ready_mode = 1;   // 0 random, 1 always, 2 toggle, 3 never
  logic [7:0]  exp_q[$];
  logic [31:0] regs[32];
  logic [31:0] mem[1024];
  bit          m_running = 1'b0;
  logic [31:0] m_cyc = 32'd0;
  int          run_edge = 0;

  // Edge counter used to measure how long the core was released
  initial forever begin
    @(posedge clk);
    tb_cyc++;
  end

  // Transmitter ready pattern
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_tx_ready = 1'($urandom_range(0, 1));
        1:       i_tx_ready = 1'b1;
        2:       i_tx_ready = ~i_tx_ready;
        default: i_tx_ready = 1'b0;
      endcase
    end
  end

  // Register file / data memory with one cycle of read latency
  initial begin
    logic [4:0]    ra;
    logic [MW-1:0] ma;
    i_dbg_reg_data = 32'd0;
    i_dbg_mem_data = 32'd0;
    forever begin
      @(negedge clk);
      ra = o_dbg_reg_addr;
      ma = o_dbg_mem_addr;
      @(posedge clk);
      #1;
      i_dbg_reg_data = regs[ra];
      i_dbg_mem_data = mem[ma];
    end
  end

  // Monitor: compare each transferred byte, and check holding while stalled
  initial begin
    logic [7:0] e;
    logic       prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (prev_hold) begin
          tests++;
          if (!(o_tx_valid === 1'b1 && o_tx_data === prev_data)) begin
            fails++;
            $display("FAIL tx_hold: got valid=%b data=%h, expected valid=1 data=%h",
                     o_tx_valid, o_tx_data, prev_data);
          end
        end
        if (o_tx_valid && i_tx_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL tx_unexpected: got %h, expected no byte", o_tx_data);
          end else begin
            e = exp_q.pop_front();
            if (o_tx_data !== e) begin
              fails++;
              $display("FAIL tx_byte: got %h, expected %h", o_tx_data, e);
            end
          end
        end
        prev_hold = o_tx_valid && !i_tx_ready;
        prev_data = o_tx_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_tx_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called right after the last argument byte has been accepted
  task automatic read_latency();
    check("rd_lat_c1", 32'(o_tx_valid), 32'd0);
    tick();
    check("rd_lat_c2", 32'(o_tx_valid), 32'd0);
    tick();
    check("rd_lat_c3", 32'(o_tx_valid), 32'd1);
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2);
    logic [MW-1:0] ma;
    if (op < 8'd1 || op > 8'd7 || (m_running && op >= 8'd3)) begin
      exp_q.push_back(ERR);
      send_byte(op);
      check("err_valid", 32'(o_tx_valid), 32'd1);
      if (m_running) check("stall_while_running", 32'(o_stall), 32'd0);
    end else begin
      case (op)
        8'd1: begin
          exp_q.push_back(ACK);
          send_byte(op);
          check("run_ack_valid", 32'(o_tx_valid), 32'd1);
          check("run_stall", 32'(o_stall), 32'd0);
          check("run_running", 32'(o_running), 32'd1);
          if (!m_running) begin
            m_running = 1'b1;
            run_edge  = tb_cyc;
          end
        end
        8'd2: begin
          exp_q.push_back(ACK);
          send_byte(op);
          check("halt_ack_valid", 32'(o_tx_valid), 32'd1);
          check("halt_stall", 32'(o_stall), 32'd1);
          check("halt_running", 32'(o_running), 32'd0);
          if (m_running) begin
            m_cyc     = m_cyc + 32'(tb_cyc - run_edge);
            m_running = 1'b0;
          end
        end
        8'd3: begin
          exp_q.push_back(ACK);
          send_byte(op);
          check("step_stall_low", 32'(o_stall), 32'd0);
          check("step_ack_early", 32'(o_tx_valid), 32'd0);
          tick();
          check("step_stall_back", 32'(o_stall), 32'd1);
          check("step_ack_valid", 32'(o_tx_valid), 32'd1);
          m_cyc = m_cyc + 32'd1;
        end
        8'd4: begin
          push_word(regs[a1[4:0]]);
          send_byte(op);
          send_byte(a1);
          read_latency();
          wait_drain();
          check("reg_addr", 32'(o_dbg_reg_addr), 32'(a1[4:0]));
        end
        8'd5: begin
          ma = MW'({a1, a2});
          push_word(mem[ma]);
          send_byte(op);
          send_byte(a1);
          send_byte(a2);
          read_latency();
          wait_drain();
          check("mem_addr", 32'(o_dbg_mem_addr), 32'(ma));
        end
        8'd6: begin
          i_dbg_pc = $urandom;
          push_word(i_dbg_pc);
          send_byte(op);
          // A byte landing during LOAD must be ignored
          i_rx_valid = 1'b1;
          i_rx_data  = 8'h01;
          tick();
          i_rx_valid = 1'b0;
          wait_drain();
        end
        default: begin
          push_word(m_cyc);
          send_byte(op);
        end
      endcase
    end
    wait_drain();
  endtask

  initial begin
    logic [7:0] op;
    int         sel;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    regs[5]     = 32'hDEAD_BEEF;
    mem[10'h3FF] = 32'h1234_5678;
    rst        = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_dbg_pc   = 32'h0040_0000;

    repeat (3) tick();
    check("rst_stall", 32'(o_stall), 32'd1);
    check("rst_running", 32'(o_running), 32'd0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_reg_addr", 32'(o_dbg_reg_addr), 32'd0);
    check("rst_mem_addr", 32'(o_dbg_mem_addr), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Counter at zero after reset, then three single steps
    ready_mode = 1;
    do_cmd(8'h07, 8'h00, 8'h00);
    repeat (3) do_cmd(8'h03, 8'h00, 8'h00);
    do_cmd(8'h07, 8'h00, 8'h00);

    // Register and memory reads with throttled transmitter
    ready_mode = 2;
    do_cmd(8'h04, 8'h25, 8'h00);
    ready_mode = 0;
    do_cmd(8'h05, 8'h03, 8'hFF);

    // Free run: reads and unknown opcodes are refused, args not consumed
    ready_mode = 1;
    do_cmd(8'h01, 8'h00, 8'h00);
    repeat (5) tick();
    do_cmd(8'h06, 8'h00, 8'h00);
    do_cmd(8'h09, 8'h00, 8'h00);
    do_cmd(8'h04, 8'h00, 8'h00);
    do_cmd(8'h01, 8'h00, 8'h00);
    do_cmd(8'h02, 8'h00, 8'h00);
    do_cmd(8'h07, 8'h00, 8'h00);
    do_cmd(8'h06, 8'h00, 8'h00);

    // Randomized command stream
    for (int k = 0; k < 80; k++) begin
      ready_mode = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      op  = (sel < 7) ? 8'(sel + 1) : 8'($urandom);
      do_cmd(op, 8'($urandom), 8'($urandom));
    end
    ready_mode = 1;
    if (m_running) do_cmd(8'h02, 8'h00, 8'h00);
    do_cmd(8'h07, 8'h00, 8'h00);

    // Reset in the middle of a 4-byte response
    ready_mode = 3;
    repeat (2) tick();
    i_dbg_pc = $urandom;
    push_word(i_dbg_pc);
    send_byte(8'h06);
    repeat (2) tick();
    check("mid_send_valid", 32'(o_tx_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_tx_valid_drop", 32'(o_tx_valid), 32'd0);
    exp_q.delete();
    m_running = 1'b0;
    m_cyc     = 32'd0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("post_rst_stall", 32'(o_stall), 32'd1);
    check("post_rst_tx_valid", 32'(o_tx_valid), 32'd0);
    ready_mode = 1;
    tick();
    do_cmd(8'h03, 8'h00, 8'h00);
    do_cmd(8'h07, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Host-side debug controller that owns the pipeline's `i_stall` input and the debug read ports of the register file, data memory and PC. It consumes command bytes from the UART receiver and returns response bytes to the UART transmitter. It runs, halts and single-steps the core, and reads back architectural state. It sits between the UART pair and the `mips` top. Its `o_stall` drives the core's stall input directly.

## Interface
- `MEM_ADDR_W`, 10: data-memory word-address width.
- `ACK_BYTE`, 8'hAC: response to RUN/HALT/STEP.
- `ERR_BYTE`, 8'hEE: response to an unknown opcode or a rejected command.

Ports:
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `i_rx_valid`  input  1  one-cycle pulse; a received byte is on `i_rx_data`.
- `i_rx_data`  input  8  received byte.
- `o_tx_valid`  output  1  a response byte is presented.
- `o_tx_data`  output  8  response byte.
- `i_tx_ready`  input  1  transmitter accepts the byte this cycle.
- `o_stall`  output  1  1 = pipeline frozen.
- `o_running`  output  1  free-run mode active.
- `o_dbg_reg_addr`  output  5  register-file debug read address.
- `i_dbg_reg_data`  input  32  register data, valid one cycle after the address.
- `o_dbg_mem_addr`  output  MEM_ADDR_W  data-memory debug word address.
- `i_dbg_mem_data`  input  32  memory data, valid one cycle after the address.
- `i_dbg_pc`  input  32  current PC, combinational.

## Operation
- **Commands** (opcode byte, then any argument bytes):
  - 0x01 RUN: set `running`, send ACK.
  - 0x02 HALT: clear `running`, send ACK.
  - 0x03 STEP: release the stall for exactly one cycle, then send ACK.
  - 0x04 RDREG: argument byte; the register index is its low 5 bits. Send 4 data bytes.
  - 0x05 RDMEM: two argument bytes, high then low. Address = {hi, lo}[MEM_ADDR_W-1:0]. Send 4 data bytes.
  - 0x06 RDPC: send 4 bytes of `i_dbg_pc`.
  - 0x07 RDCYC: send 4 bytes of the cycle counter.
- **Data order:** multi-byte responses are sent MSB first.
- **While `running`:** only RUN and HALT are executed. Opcodes 0x03–0x07 send ERR_BYTE and consume no argument bytes. Any other opcode always sends ERR_BYTE.
- **Stall output:** `o_stall` = ~(`running` | `step_pulse`).
- **Cycle counter:** 32-bit, increments on every cycle with `o_stall`=0, wraps from 0xFFFFFFFF to 0. It is not cleared by HALT.
- **FSM states:**
  - IDLE: wait for an opcode byte.
  - ARG1: wait for the first argument byte.
  - ARG2: wait for the second argument byte.
  - STEP: one cycle with `step_pulse`=1.
  - WAIT_RD: one cycle; the read address is stable.
  - LOAD: capture the selected 32-bit source into the shift register.
  - SEND: shift out the captured word, 4 bytes.
  - SEND1: send a single byte (ACK_BYTE or ERR_BYTE).
- **Transitions:**
  - IDLE → ARG1 on RDREG or RDMEM.
  - IDLE → LOAD on RDPC or RDCYC.
  - IDLE → STEP on STEP.
  - IDLE → SEND1 on RUN, HALT, error or rejection.
  - ARG1 → WAIT_RD for RDREG; ARG1 → ARG2 for RDMEM.
  - ARG2 → WAIT_RD.
  - STEP → SEND1.
  - WAIT_RD → LOAD.
  - LOAD → SEND.
  - SEND → IDLE after the 4th accepted byte.
  - SEND1 → IDLE on `i_tx_ready`.
- **Received bytes:** bytes arriving in STEP, WAIT_RD, LOAD, SEND or SEND1 are discarded. There is no receive back-pressure; the host waits for the full response before sending again.

## Timing
- **Reset values:** `o_stall`=1, `o_running`=0, `o_tx_valid`=0, `o_tx_data`=0, `o_dbg_reg_addr`=0, `o_dbg_mem_addr`=0, cycle counter=0, FSM=IDLE.
- **Reset during a transfer:** the transfer is aborted; `o_tx_valid` falls asynchronously.
- **Byte acceptance:** a byte is accepted in the cycle where `i_rx_valid`=1. The state change is visible on the next edge.
- **RUN/HALT:** `o_stall` changes in the cycle after the opcode is accepted. The ACK is presented in that same cycle.
- **STEP:** `o_stall`=0 for exactly the one cycle following acceptance of the opcode. The counter increments by exactly 1. The ACK is presented on the next cycle.
- **Read addresses:** `o_dbg_*_addr` are registered in the cycle after the last argument byte and held until the next read.
- **Read latency:** the data is captured one cycle after the address (WAIT_RD → LOAD). The first response byte appears 3 cycles after the last argument byte.
- **RDCYC:** captures the counter value at LOAD.
- **Transmit handshake:** `o_tx_valid` and `o_tx_data` are held stable until `i_tx_ready`=1. A byte transfers on a cycle with valid & ready. The next byte may be presented on the following cycle. `o_tx_valid` never drops without a transfer, except on reset.
- **Simultaneous HALT and counting:** a HALT accepted while running still counts the cycle of acceptance, because the stall is released until the next edge.

## Test plan
1. Reset, then RDCYC with `i_tx_ready`=1 → `o_stall`=1, response 00 00 00 00.
2. STEP three times, then RDCYC → three ACKs (0xAC); `o_stall` low for exactly 1 cycle each; response 00 00 00 03.
3. RDREG 0x25, with `i_dbg_reg_data`=0xDEADBEEF when the address is 5 → `o_dbg_reg_addr`=5; response DE AD BE EF; `i_tx_ready` toggled every other cycle, with no byte dropped or duplicated.
4. RDMEM 0x03 0xFF → `o_dbg_mem_addr`=0x3FF; `i_dbg_mem_data`=0x12345678 yields 12 34 56 78.
5. RUN, RDPC, 0x09, HALT → responses AC, EE, EE, AC. `o_stall` stays 0 between the RUN and HALT ACKs. The counter advances by the number of released cycles.
6. Reset asserted midway through a 4-byte SEND → `o_tx_valid` falls immediately; after release, `o_stall`=1 and the FSM accepts a new opcode.
